step_fetch: RTL
===============

# step_fetch

Fetch/dispatch step of the 8-bit core. On a start pulse it reads the byte at PC into the instruction register, increments PC, and pulses the enable of the execute step selected by the opcode (`ir[7:4]`). It then waits for that step's completion and reports its own completion upstream. It sits directly upstream of the `step_ex_*` blocks and shares their open-drain and tri-state bus discipline.

## Interface
Parameters:
- none

Ports:
- `clk` in 1: clock; all state updates on the rising edge.
- `rst_` in 1: reset, asynchronous, active-low.
- `ena_` in 1: start request, active-low, sampled at posedge.
- `rdy_` out 1: open-drain; 0 for one cycle on completion, Z otherwise.
- `mem_re_` out 1: open-drain memory read strobe; 0 or Z.
- `abus` out 8: address bus; carries `pc_dout` while fetching, Z otherwise.
- `dbus` in 8: memory data bus.
- `pc_dout` in 8: current PC value.
- `pc_din` out 8: next PC value, `pc_dout+1`, driven while `pc_we_` is low; Z otherwise.
- `pc_we_` out 1: open-drain PC write strobe.
- `ir` out 8: instruction register, always driven.
- `ex_ena_` out 16: per-step execute enables, active-low open-drain; bit n drives 0 or Z.
- `ex_rdy_` in 1: wired-low completion line from all execute steps (pulled up externally).
- `fault_` out 1: open-drain watchdog fault; see Configuration.

## Operation
- State register holds one of IDLE, FETCH, INC, DISPATCH, WAIT, DONE. Each output enable is a registered flag; the bus and strobe pins are gated from those flags.
- IDLE: leave when `ena_`=0 is sampled → FETCH. Otherwise remain in IDLE.
- FETCH (1 cycle):
  - `mem_re_`=0 and `abus`=`pc_dout`.
  - At the closing edge, `ir` ← `dbus`. Go to INC.
- INC (1 cycle): `pc_din`=`pc_dout+1`, mod 256 (0xFF wraps to 0x00); `pc_we_`=0. Go to DISPATCH.
- DISPATCH (1 cycle): `ex_ena_[ir[7:4]]`=0; all other bits Z. Go to WAIT.
- WAIT: stay until `ex_rdy_`=0 is sampled → DONE.
- DONE (1 cycle): `rdy_`=0. Go to IDLE.
- Request and completion sampling rules:
  - `ena_` is ignored in every state except IDLE, and in DONE as described under Timing.
  - `ex_rdy_` is ignored outside WAIT.
- `ir` changes only at the end of FETCH, so it is stable for the whole execute step.
- Reset (asynchronous, also mid-operation):
  - State → IDLE and `ir` → 0x00.
  - All open-drain outputs go Z, and `abus` and `pc_din` go Z, immediately.
  - Watchdog counter → 0 and fault cleared.

## Timing
- `ena_` is sampled low at edge E0. FETCH runs E0–E1, INC E1–E2, and DISPATCH E2–E3. WAIT begins at E3.
- If `ex_rdy_` is first sampled low at edge Ek (k ≥ 4), DONE runs Ek to Ek+1, so `rdy_` is low for exactly one cycle.
- Minimum `ena_`→`rdy_` latency is 4 cycles plus the execute step's latency.
- Back-to-back operation: `ena_` sampled low at the edge that ends DONE starts FETCH immediately, with no idle cycle.
- At most one strobe (`mem_re_`, `pc_we_`, `ex_ena_`, `rdy_`) is low in any cycle.

## Configuration
- `STEP_FETCH_WDT_EN` defined:
  - An 8-bit counter clears on entry to WAIT and increments each cycle in WAIT.
  - If the counter reaches 255 without `ex_rdy_`=0, go to IDLE without pulsing `rdy_`.
  - `fault_` is then held at 0 until reset.
  - While `fault_` is latched, `ena_` is ignored.
- `STEP_FETCH_WDT_EN` undefined: WAIT is unbounded, no counter exists, and `fault_` is constant Z.

## Test plan
- Reset with `ena_`=1: every open-drain output and `abus`/`pc_din` are Z, and `ir`=0x00. Pulse `rst_` low during WAIT: same response, immediately and without a clock edge.
- `pc_dout`=0x12, memory[0x12]=0x3A, `ena_` pulsed:
  - `abus`=0x12 with `mem_re_`=0 for 1 cycle.
  - Then `pc_din`=0x13 with `pc_we_`=0.
  - Then `ex_ena_[3]`=0 with other bits Z, and `ir`=0x3A.
  - `ex_rdy_` low 3 cycles later → `rdy_`=0 for exactly 1 cycle.
- `pc_dout`=0xFF: `pc_din`=0x00 in INC.
- Hold `ena_` low continuously while `ex_rdy_` responds after 2 cycles: consecutive fetches with no gap after DONE. Spurious `ex_rdy_` pulses during FETCH and INC are ignored, and `ena_` low during WAIT does not restart.
- With `STEP_FETCH_WDT_EN`, `ex_rdy_` held high: after 255 WAIT cycles `fault_`=0 with no `rdy_` pulse, and later `ena_` pulses are ignored until reset.
- Without `STEP_FETCH_WDT_EN`, `ex_rdy_` held high: the block stays in WAIT for at least 1000 cycles and `fault_` stays Z.

Source files
------------

// File: rtl/step_fetch.sv
// -----------------------------------------------------------------------------
// step_fetch -- fetch/dispatch step of the 8-bit core.
//
// On a start request it reads the byte at PC into the instruction register,
// writes PC+1 back to the PC, pulses the enable of the execute step selected
// by ir[7:4], waits for the wired-low completion line and then reports its own
// completion upstream.
//
// Optional feature (compile-time macro): STEP_FETCH_WDT_EN
//   defined   : an 8-bit watchdog bounds WAIT. A timeout returns to IDLE
//               without a completion pulse and latches fault_ low until reset.
//   undefined : WAIT is unbounded and fault_ is constant Z.
//
// Ports
//   clk      in       clock, rising edge
//   rst_     in       asynchronous active-low reset
//   ena_     in       start request, active-low, sampled at posedge
//   rdy_     out      open-drain completion pulse (0 for one cycle, else Z)
//   mem_re_  out      open-drain memory read strobe
//   abus     out [8]  address bus, pc_dout while fetching, else Z
//   dbus     in  [8]  memory data bus
//   pc_dout  in  [8]  current PC value
//   pc_din   out [8]  pc_dout+1 while pc_we_ is low, else Z
//   pc_we_   out      open-drain PC write strobe
//   ir       out [8]  instruction register, always driven
//   ex_ena_  out [16] per-step execute enables, open-drain, one-hot low
//   ex_rdy_  in       wired-low completion from all execute steps
//   fault_   out      open-drain watchdog fault
//
// Handshake: a request is accepted when ena_ is sampled low in IDLE (or in
// DONE, for back-to-back operation). Completion of the execute step is
// accepted only when ex_rdy_ is sampled low in WAIT. rdy_ is low for exactly
// the one DONE cycle. At most one of mem_re_, pc_we_, ex_ena_, rdy_ is low in
// any cycle because each is tied to a distinct state.
// -----------------------------------------------------------------------------
module step_fetch (
  input  logic        clk,
  input  logic        rst_,
  input  logic        ena_,
  output logic        rdy_,
  output logic        mem_re_,
  output logic [7:0]  abus,
  input  logic [7:0]  dbus,
  input  logic [7:0]  pc_dout,
  output logic [7:0]  pc_din,
  output logic        pc_we_,
  output logic [7:0]  ir,
  output logic [15:0] ex_ena_,
  input  logic        ex_rdy_,
  output logic        fault_
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_FETCH    = 3'd1,
    S_INC      = 3'd2,
    S_DISPATCH = 3'd3,
    S_WAIT     = 3'd4,
    S_DONE     = 3'd5
  } state_t;

  state_t      state_q;

  // Registered output-enable flags; each is set on the edge that enters the
  // state in which its strobe is active, so pins never glitch from decode.
  logic        mem_re_q;
  logic        pc_we_q;
  logic        ex_q;
  logic        rdy_q;
  logic [7:0]  ir_q;
  logic [15:0] ex_sel;
  logic        start_ok;

`ifdef STEP_FETCH_WDT_EN
  logic [7:0]  wdt_cnt;
  logic        fault_q;

  // A latched fault blocks new requests until reset.
  assign start_ok = ~ena_ & ~fault_q;
`else
  assign start_ok = ~ena_;
`endif

  // ---------------------------------------------------------------------------
  // Control FSM and output-enable flags
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q  <= S_IDLE;
      ir_q     <= 8'h00;
      mem_re_q <= 1'b0;
      pc_we_q  <= 1'b0;
      ex_q     <= 1'b0;
      rdy_q    <= 1'b0;
`ifdef STEP_FETCH_WDT_EN
      wdt_cnt  <= 8'd0;
      fault_q  <= 1'b0;
`endif
    end else begin
      // Strobes default inactive; only the transition into their state sets them.
      mem_re_q <= 1'b0;
      pc_we_q  <= 1'b0;
      ex_q     <= 1'b0;
      rdy_q    <= 1'b0;

      case (state_q)
        S_IDLE: begin
          if (start_ok) begin
            state_q  <= S_FETCH;
            mem_re_q <= 1'b1;
          end
        end

        S_FETCH: begin
          // ir only changes here, so it is stable for the whole execute step.
          ir_q    <= dbus;
          state_q <= S_INC;
          pc_we_q <= 1'b1;
        end

        S_INC: begin
          state_q <= S_DISPATCH;
          ex_q    <= 1'b1;
        end

        S_DISPATCH: begin
          state_q <= S_WAIT;
`ifdef STEP_FETCH_WDT_EN
          wdt_cnt <= 8'd0;
`endif
        end

        S_WAIT: begin
          if (!ex_rdy_) begin
            state_q <= S_DONE;
            rdy_q   <= 1'b1;
          end
`ifdef STEP_FETCH_WDT_EN
          // Count reaches 255 on this edge: the step has had 255 WAIT cycles.
          else if (wdt_cnt == 8'd254) begin
            state_q <= S_IDLE;
            wdt_cnt <= 8'd255;
            fault_q <= 1'b1;
          end else begin
            wdt_cnt <= wdt_cnt + 8'd1;
          end
`endif
        end

        S_DONE: begin
          // A request already pending at the end of DONE starts the next
          // fetch with no idle cycle in between.
          if (start_ok) begin
            state_q  <= S_FETCH;
            mem_re_q <= 1'b1;
          end else begin
            state_q  <= S_IDLE;
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Pin drivers gated from the registered flags
  // ---------------------------------------------------------------------------
  assign ir      = ir_q;
  assign mem_re_ = mem_re_q ? 1'b0 : 1'bz;
  assign abus    = mem_re_q ? pc_dout : 8'hzz;
  assign pc_we_  = pc_we_q ? 1'b0 : 1'bz;
  assign pc_din  = pc_we_q ? (pc_dout + 8'd1) : 8'hzz;
  assign rdy_    = rdy_q ? 1'b0 : 1'bz;

  // One-hot decode of the opcode nibble; only the selected bit is pulled low.
  always_comb begin
    ex_sel = 16'd0;
    if (ex_q) begin
      ex_sel = 16'd1 << ir_q[7:4];
    end
  end

  for (genvar n = 0; n < 16; n++) begin : g_ex_ena
    assign ex_ena_[n] = ex_sel[n] ? 1'b0 : 1'bz;
  end

`ifdef STEP_FETCH_WDT_EN
  assign fault_ = fault_q ? 1'b0 : 1'bz;
`else
  assign fault_ = 1'bz;
`endif

endmodule
